// File: rtl/stream_gather_pkg.sv
// stream_gather_pkg -- shared helpers for the stream_gather slice.
// Rev 1.0
`default_nettype none

package stream_gather_pkg;

  // Slot pointer width; a one-entry table still gets a 1-bit pointer.
  function automatic int slot_width(input int blen);
    return (blen > 1) ? $clog2(blen) : 1;
  endfunction

  // Round-robin table entry, handy for building a BTable that visits every input.
  function automatic int default_entry(input int slot, input int num_in);
    return (num_in > 0) ? (slot % num_in) : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_gather_if.sv
// stream_gather_if -- per-input valid/ready/data plus merged output and slot index.
// Rev 1.0
`default_nettype none

interface stream_gather_if
  import stream_gather_pkg::*;
#(
  parameter int unsigned NumIn     = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BLen      = 2
);
  localparam int SlotW = slot_width(int'(BLen));

  logic [NumIn-1:0]                valid_i;
  logic [NumIn-1:0]                ready_o;
  logic [NumIn-1:0][DataWidth-1:0] data_i;
  logic                            valid_o;
  logic                            ready_i;
  logic [DataWidth-1:0]            data_o;
  logic [SlotW-1:0]                slot_o;

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, slot_o
  );

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, slot_o
  );

endinterface

`default_nettype wire

// File: rtl/stream_gather_reg.sv
// stream_gather_reg -- one-entry valid/ready pipeline register, full throughput.
// Rev 1.0
`default_nettype none

module stream_gather_reg #(
  parameter int unsigned DataWidth = 32
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  input  wire logic                 in_valid,
  output logic                      in_ready,
  input  wire logic [DataWidth-1:0] in_data,
  output logic                      out_valid,
  input  wire logic                 out_ready,
  output logic [DataWidth-1:0]      out_data
);

  logic                 full;
  logic [DataWidth-1:0] held_data;

  // Accept while empty, or while the held word leaves in the same cycle.
  assign in_ready = !full || out_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full      <= 1'b0;
      held_data <= '0;
    end else if (in_valid && in_ready) begin
      full      <= 1'b1;
      held_data <= in_data;
    end else if (out_ready) begin
      full      <= 1'b0;
    end
  end

  assign out_valid = full;
  assign out_data  = held_data;

endmodule

`default_nettype wire

// File: rtl/stream_gather.sv
// stream_gather -- merges NumIn streams in BTable slot order; define
// STREAM_GATHER_OUT_REG_EN for a registered output. Rev 1.0
`default_nettype none

module stream_gather
  import stream_gather_pkg::*;
#(
  parameter int unsigned      NumIn     = 2,
  parameter int unsigned      BLen      = 2,
  parameter int unsigned      DataWidth = 32,
  parameter type              addr_t    = logic [$clog2(NumIn)-1:0],
  parameter addr_t [BLen-1:0] BTable    = '0
) (
  input  wire logic      clk_i,
  input  wire logic      rst_ni,
  input  wire logic      clr_i,
  stream_gather_if.slave bus
);

  localparam int               SlotW    = slot_width(int'(BLen));
  localparam logic [SlotW-1:0] LastSlot = SlotW'(BLen - 1);

  logic [SlotW-1:0]     cur_slot;
  addr_t                sel;
  logic                 sel_ok;
  logic                 sel_valid;
  logic [DataWidth-1:0] sel_data;
  logic                 path_ready;
  logic                 accept_ready;
  logic                 fire;

  if (BLen == 1) begin : g_single
    assign sel = BTable[0];
  end else begin : g_table
    assign sel = BTable[cur_slot];
  end

  // Out-of-range table entries match no input, leaving the slot stalled.
  always_comb begin
    sel_ok    = 1'b0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      if (sel == addr_t'(i)) begin
        sel_ok    = 1'b1;
        sel_valid = bus.valid_i[i];
        sel_data  = bus.data_i[i];
      end
    end
  end

  assign accept_ready = rst_ni && !clr_i && path_ready;
  assign fire         = sel_valid && accept_ready;

  always_comb begin
    bus.ready_o = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      if (sel == addr_t'(i)) begin
        bus.ready_o[i] = accept_ready;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_slot <= '0;
    end else if (clr_i) begin
      cur_slot <= '0;
    end else if (fire) begin
      cur_slot <= (cur_slot == LastSlot) ? '0 : cur_slot + 1'b1;
    end
  end

  assign bus.slot_o = cur_slot;

`ifdef STREAM_GATHER_OUT_REG_EN
  stream_gather_reg #(
    .DataWidth (DataWidth)
  ) u_out_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (sel_valid && !clr_i),
    .in_ready  (path_ready),
    .in_data   (sel_data),
    .out_valid (bus.valid_o),
    .out_ready (bus.ready_i),
    .out_data  (bus.data_o)
  );
`else
  // Zero-latency path; reset forces the outputs quiet since nothing is registered.
  assign path_ready  = bus.ready_i;
  assign bus.valid_o = rst_ni && sel_valid && !clr_i;
  assign bus.data_o  = rst_ni ? sel_data : '0;
`endif

`ifndef SYNTHESIS
  if (NumIn == 0) begin : g_chk_num_in
    $error("stream_gather: NumIn must be at least 1");
  end
  if (BLen == 0) begin : g_chk_blen
    $error("stream_gather: BLen must be at least 1");
  end

  sel_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni) sel_ok)
    else $error("stream_gather: table selects input %0d, NumIn is %0d", sel, NumIn);
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_gather.sv
// tb_stream_gather -- random and directed traffic against a queue-based gather model.
// Rev 1.0
`default_nettype none

module tb_stream_gather;

  localparam int               NUM_IN = 2;
  localparam int               B_LEN  = 4;
  localparam int               DW     = 32;
  localparam logic [B_LEN-1:0] TBL    = 4'b1001;
`ifdef STREAM_GATHER_OUT_REG_EN
  localparam int OUT_LAT = 1;
`else
  localparam int OUT_LAT = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  stream_gather_if #(.NumIn(NUM_IN), .DataWidth(DW), .BLen(B_LEN)) bus ();

  stream_gather #(
    .NumIn     (NUM_IN),
    .BLen      (B_LEN),
    .DataWidth (DW),
    .BTable    (TBL)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          tbl[B_LEN]   = '{1, 0, 0, 1};
  int          order[8]     = '{1, 0, 0, 1, 1, 0, 0, 1};
  int          seq[NUM_IN]  = '{0, 0};
  int          mslot        = 0;
  int          n_acc        = 0;
  int          n_vec        = 0;
  int          n_err        = 0;
  logic [31:0] held[$];

  logic [1:0]  s_ready_o;
  logic        s_valid_o;
  logic [31:0] s_data_o;
  logic [1:0]  s_slot_o;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word tag: source index in the top byte, per-source sequence number below.
  function automatic logic [31:0] word(input int k);
    logic [31:0] s;
    s = 32'(seq[k]);
    return {8'(k), s[23:0]};
  endfunction

  task automatic eval();
    int          sel;
    logic [1:0]  er;
    logic        ev;
    logic [31:0] ed;
    logic        exp_rdy;
    logic        in_fire;
    sel       = tbl[mslot];
    s_ready_o = bus.ready_o;
    s_valid_o = bus.valid_o;
    s_data_o  = bus.data_o;
    s_slot_o  = bus.slot_o;
`ifdef STREAM_GATHER_OUT_REG_EN
    exp_rdy = !clr && (held.size() == 0 || bus.ready_i);
    ev      = (held.size() != 0);
    ed      = ev ? held[0] : 32'h0;
`else
    exp_rdy = !clr && bus.ready_i;
    ev      = bus.valid_i[sel] && !clr;
    ed      = word(sel);
`endif
    er = exp_rdy ? 2'(1 << sel) : 2'b00;
    check("ready_o", 64'(s_ready_o), 64'(er));
    check("slot_o", 64'(s_slot_o), 64'(mslot));
    check("valid_o", 64'(s_valid_o), 64'(ev));
    if (ev) check("data_o", 64'(s_data_o), 64'(ed));
    in_fire = exp_rdy && bus.valid_i[sel];
`ifdef STREAM_GATHER_OUT_REG_EN
    if (ev && bus.ready_i) void'(held.pop_front());
    if (in_fire) held.push_back(word(sel));
`endif
    if (in_fire) begin
      seq[sel]++;
      n_acc++;
      mslot = (mslot + 1) % B_LEN;
    end
    if (clr) mslot = 0;
  endtask

  task automatic step(input logic [1:0] v, input logic r, input logic c);
    bus.valid_i = v;
    bus.ready_i = r;
    clr         = c;
    for (int k = 0; k < NUM_IN; k++) bus.data_i[k] = word(k);
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_n       = 1'b0;
    bus.valid_i = '0;
    bus.ready_i = 1'b0;
    clr         = 1'b0;
    #1;
    check("arst_valid", 64'(bus.valid_o), 64'(0));
    check("arst_slot", 64'(bus.slot_o), 64'(0));
    check("arst_ready", 64'(bus.ready_o), 64'(0));
    held.delete();
    mslot = 0;
    @(negedge clk);
    check("arst_data", 64'(bus.data_o), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic first_word_after_reset();
    bit seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step(2'b11, 1'b1, 1'b0);
      if (s_valid_o) begin
        check("rst_first_src", 64'(s_data_o[31:24]), 64'(tbl[0]));
        seen = 1'b1;
      end
    end
    check("rst_first_seen", 64'(seen), 64'(1));
  endtask

  initial begin
    int got;
    int steps;
    logic [1:0] v;

    bus.valid_i = 2'b11;
    bus.ready_i = 1'b1;
    bus.data_i  = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 64'(bus.valid_o), 64'(0));
      check("rst_ready", 64'(bus.ready_o), 64'(0));
      check("rst_data", 64'(bus.data_o), 64'(0));
      check("rst_slot", 64'(bus.slot_o), 64'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate source order with every input valid and the sink always ready.
    got   = 0;
    steps = 0;
    while (got < 8 && steps < 12) begin
      step(2'b11, 1'b1, 1'b0);
      steps++;
      if (s_valid_o) begin
        check("order_src", 64'(s_data_o[31:24]), 64'(order[got]));
        got++;
      end
    end
    check("order_count", 64'(got), 64'(8));
    check("order_cycles", 64'(steps), 64'(8 + OUT_LAT));

    step(2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b0);

    // Slot 0 wants input 1; a valid input 0 must not be taken.
    step(2'b01, 1'b1, 1'b0);
    check("stall_ready", 64'(s_ready_o), 64'(2'b10));
    check("stall_slot", 64'(s_slot_o), 64'(0));
    step(2'b01, 1'b1, 1'b0);
    check("stall_hold", 64'(s_slot_o), 64'(0));
    step(2'b10, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    check("stall_release", 64'(s_slot_o), 64'(1));

    for (int i = 0; i < 5; i++) begin
      step(2'b11, 1'b0, 1'b0);
      if (i > 0) check("bp_ready", 64'(s_ready_o), 64'(0));
    end
    repeat (3) step(2'b11, 1'b1, 1'b0);

    for (int i = 0; i < 8 && mslot != 2; i++) step(2'b11, 1'b1, 1'b0);
    check("clr_reach_slot2", 64'(mslot), 64'(2));
    step(2'b11, 1'b1, 1'b1);
    check("clr_ready", 64'(s_ready_o), 64'(0));
    check("clr_held_out", 64'(s_valid_o), 64'(OUT_LAT));
    step(2'b11, 1'b1, 1'b0);
    check("clr_slot", 64'(s_slot_o), 64'(0));
    check("clr_sel", 64'(s_ready_o), 64'(2'b10));

    step(2'b11, 1'b0, 1'b0);
    async_reset();
    first_word_after_reset();

    steps = 0;
    got   = n_acc + 10000;
    while (n_acc < got && steps < 60000) begin
      for (int k = 0; k < NUM_IN; k++) v[k] = ($urandom_range(0, 99) < 75);
      step(v, ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 1));
      steps++;
      if (steps == 9000) begin
        async_reset();
        first_word_after_reset();
      end
    end
    check("xfer_budget", 64'(n_acc >= got), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
